ddr_deserializer: RTL and testbench

//   Receive end of a dual-edge (DDR) serial link.
//   - The transmitter drives one data bit per clock edge on din.
//   - This block captures din on both edges of clk and assembles bit pairs
//     MSB-first into WORD_W-bit words.
//   - Completed words are presented on a valid/ready output port.
//   - Sits between a dual-edge driver and single-edge (posedge) logic.

---
 rtl/ddr_deserializer_if.sv | 32 +++
 rtl/ddr_deserializer.sv | 107 ++++++++++
 tb/tb_ddr_deserializer.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_deserializer_if.sv
// ============================================================================
// Module      : ddr_deserializer_if
// Description : Serial-in / word-out bundle of the DDR deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ddr_deserializer_if #(
  parameter int WORD_W = 8
);
  logic              din;
  logic              din_vld;
  logic              din_sof;
  logic [WORD_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              overflow;
  logic              clr_ovf;

  // master: link driver plus word consumer; slave: the deserializer
  modport master (
    output din, din_vld, din_sof, dout_ready, clr_ovf,
    input  dout, dout_valid, overflow
  );

  modport slave (
    input  din, din_vld, din_sof, dout_ready, clr_ovf,
    output dout, dout_valid, overflow
  );
endinterface

`default_nettype wire

// File: rtl/ddr_deserializer.sv
// ============================================================================
// Module      : ddr_deserializer
// Description : Dual-edge serial receiver assembling MSB-first bit pairs into
//               WORD_W-bit words on a valid/ready output with sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_deserializer #(
  parameter int WORD_W = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  ddr_deserializer_if.slave  bus
);

  localparam int                 c_PAIRS = WORD_W / 2;
  localparam int                 c_CNT_W = $clog2(c_PAIRS);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_PAIRS - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  logic              r_a;
  logic              r_v;
  logic              r_s;
  logic              r_b;
  logic [WORD_W-1:0] r_sh;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WORD_W-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_ovf;

  logic [WORD_W-1:0] w_next_sh;
  logic              w_complete;
  logic              w_load;
  logic              w_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= 1'b0;
      r_v <= 1'b0;
      r_s <= 1'b0;
    end else begin
      r_a <= bus.din;
      r_v <= bus.din_vld;
      r_s <= bus.din_sof;
    end
  end

  // Second bit of the pair arrives on the falling edge of the same cycle
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b <= 1'b0;
    end else begin
      r_b <= bus.din;
    end
  end

  assign w_next_sh  = {r_sh[WORD_W-3:0], r_a, r_b};
  // A start-of-frame pair is always pair 0, so it can never complete a word
  assign w_complete = r_v & ~r_s & (r_cnt == c_LAST);
  assign w_load     = w_complete & (~r_dout_valid | bus.dout_ready);
  assign w_drop     = w_complete & ~w_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (r_v) begin
      r_sh <= w_next_sh;
      if (r_s) begin
        r_cnt <= c_ONE;
      end else if (r_cnt == c_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      if (w_load) begin
        r_dout       <= w_next_sh;
        r_dout_valid <= 1'b1;
      end else if (bus.dout_ready) begin
        r_dout_valid <= 1'b0;
      end
      // A drop on the clearing edge keeps the flag set
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (bus.clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.overflow   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_ddr_deserializer.sv
// ============================================================================
// Module      : tb_ddr_deserializer
// Description : Self-checking bench for ddr_deserializer with a word-level
//               reference model of pair assembly and the output slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ddr_deserializer;

  localparam int WORD_W = 8;
  localparam int PAIRS  = WORD_W / 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ddr_deserializer_if #(.WORD_W(WORD_W)) bus ();

  ddr_deserializer #(.WORD_W(WORD_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: word value accumulated arithmetically, plus output slot
  int                m_acc;
  int                m_npairs;
  logic              m_pv;
  logic              m_ps;
  logic [1:0]        m_pp;
  logic [WORD_W-1:0] e_dout;
  logic              e_valid;
  logic              e_ovf;

  task automatic model_reset();
    m_acc    = 0;
    m_npairs = 0;
    m_pv     = 1'b0;
    m_ps     = 1'b0;
    m_pp     = 2'b00;
    e_dout   = '0;
    e_valid  = 1'b0;
    e_ovf    = 1'b0;
  endtask

  // Effect of one rising edge given the pair sampled on the previous edge
  task automatic model_edge(input logic rdy, input logic clr);
    bit done;
    bit drop;
    int word;
    done = 0;
    word = 0;
    if (m_pv) begin
      if (m_ps) begin
        m_acc    = int'(m_pp);
        m_npairs = 1;
      end else begin
        m_acc    = m_acc * 4 + int'(m_pp);
        m_npairs = m_npairs + 1;
      end
      if (m_npairs == PAIRS) begin
        done     = 1;
        word     = m_acc;
        m_acc    = 0;
        m_npairs = 0;
      end
    end
    drop = done && e_valid && !rdy;
    if (done && !drop) begin
      e_dout  = word[WORD_W-1:0];
      e_valid = 1'b1;
    end else if (e_valid && rdy) begin
      e_valid = 1'b0;
    end
    if (drop)     e_ovf = 1'b1;
    else if (clr) e_ovf = 1'b0;
  endtask

  // One clock: first bit ahead of the rising edge, second ahead of the falling edge
  task automatic drive_cycle(input logic vld, input logic sof, input logic a,
                             input logic b, input logic rdy, input logic clr);
    @(negedge clk);
    #1;
    bus.din        = a;
    bus.din_vld    = vld;
    bus.din_sof    = sof;
    bus.dout_ready = rdy;
    bus.clr_ovf    = clr;
    model_edge(rdy, clr);
    m_pv = vld;
    m_ps = sof;
    m_pp = {a, b};
    @(posedge clk);
    #1;
    bus.din = b;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w, input logic rdy, input logic clr);
    for (int p = 0; p < PAIRS; p++)
      drive_cycle(1'b1, p == 0, w[WORD_W-1-2*p], w[WORD_W-2-2*p], rdy, clr);
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (bus.dout !== '0) begin
      n_fail++; $display("FAIL reset_dout: got %h expected 0", bus.dout);
    end
    n_checks++;
    if (bus.dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.dout_valid);
    end
    n_checks++;
    if (bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_ovf: got %b expected 0", bus.overflow);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [WORD_W-1:0] w;
    int vc;
    w  = 8'hA5;
    vc = 0;
    for (int i = 0; i < PAIRS + 3; i++) begin
      if (i < PAIRS) drive_cycle(1'b1, i == 0, w[WORD_W-1-2*i], w[WORD_W-2-2*i], 1'b1, 1'b0);
      else           drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({bus.dout, bus.dout_valid, bus.overflow} !== {e_dout, e_valid, e_ovf}) begin
        n_fail++;
        $display("FAIL basic_cycle%0d: got %h/%b/%b expected %h/%b/%b", i,
                 bus.dout, bus.dout_valid, bus.overflow, e_dout, e_valid, e_ovf);
      end
      if (bus.dout_valid === 1'b1) vc++;
      if (i == PAIRS) begin
        n_checks++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 8'hA5) begin
          n_fail++;
          $display("FAIL basic_latency: got valid=%b dout=%h expected valid=1 dout=a5",
                   bus.dout_valid, bus.dout);
        end
      end
    end
    n_checks++;
    if (vc !== 1) begin
      n_fail++; $display("FAIL basic_valid_width: got %0d cycles expected 1", vc);
    end
  endtask

  task automatic test_gaps();
    logic [WORD_W-1:0] w;
    int sched [9];
    int vc;
    w     = 8'hA5;
    sched = '{0, 1, -1, -1, -1, 2, 3, -1, -1};
    vc    = 0;
    for (int i = 0; i < 9; i++) begin
      if (sched[i] >= 0)
        drive_cycle(1'b1, sched[i] == 0, w[WORD_W-1-2*sched[i]], w[WORD_W-2-2*sched[i]], 1'b1, 1'b0);
      else
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({bus.dout, bus.dout_valid, bus.overflow} !== {e_dout, e_valid, e_ovf}) begin
        n_fail++;
        $display("FAIL gaps_cycle%0d: got %h/%b/%b expected %h/%b/%b", i,
                 bus.dout, bus.dout_valid, bus.overflow, e_dout, e_valid, e_ovf);
      end
      if (bus.dout_valid === 1'b1) begin
        vc++;
        n_checks++;
        if (i != 7 || bus.dout !== 8'hA5) begin
          n_fail++; $display("FAIL gaps_word: cycle %0d dout=%h expected cycle 7 dout=a5", i, bus.dout);
        end
      end
    end
    n_checks++;
    if (vc !== 1) begin
      n_fail++; $display("FAIL gaps_count: got %0d words expected 1", vc);
    end
  endtask

  task automatic test_backpressure();
    send_word(8'h3C, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(8'hFF, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.dout !== 8'h3C || bus.dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold: got dout=%h valid=%b expected 3c/1", bus.dout, bus.dout_valid);
    end
    n_checks++;
    if (bus.overflow !== 1'b1) begin
      n_fail++; $display("FAIL bp_overflow: got %b expected 1", bus.overflow);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (bus.dout_valid !== 1'b0 || bus.overflow !== 1'b1) begin
      n_fail++; $display("FAIL bp_accept: got valid=%b ovf=%b expected 0/1", bus.dout_valid, bus.overflow);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if ({bus.dout, bus.dout_valid, bus.overflow} !== {e_dout, e_valid, e_ovf} || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_clear: got %h/%b/%b expected %h/%b/0", bus.dout, bus.dout_valid,
               bus.overflow, e_dout, e_valid);
    end
  endtask

  task automatic test_resync();
    logic [WORD_W-1:0] junk;
    logic [WORD_W-1:0] w;
    int vc;
    junk = 8'hC3;
    w    = 8'h1F;
    vc   = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 2)      drive_cycle(1'b1, i == 0, junk[WORD_W-1-2*i], junk[WORD_W-2-2*i], 1'b1, 1'b0);
      else if (i < 6) drive_cycle(1'b1, i == 2, w[WORD_W-1-2*(i-2)], w[WORD_W-2-2*(i-2)], 1'b1, 1'b0);
      else            drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({bus.dout, bus.dout_valid, bus.overflow} !== {e_dout, e_valid, e_ovf}) begin
        n_fail++;
        $display("FAIL resync_cycle%0d: got %h/%b/%b expected %h/%b/%b", i,
                 bus.dout, bus.dout_valid, bus.overflow, e_dout, e_valid, e_ovf);
      end
      if (bus.dout_valid === 1'b1) begin
        vc++;
        n_checks++;
        if (bus.dout !== 8'h1F) begin
          n_fail++; $display("FAIL resync_word: got %h expected 1f", bus.dout);
        end
      end
    end
    n_checks++;
    if (vc !== 1) begin
      n_fail++; $display("FAIL resync_count: got %0d words expected 1", vc);
    end
  endtask

  task automatic test_reset_mid();
    logic [WORD_W-1:0] w;
    w = 8'hE7;
    drive_cycle(1'b1, 1'b1, w[7], w[6], 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b0, w[5], w[4], 1'b1, 1'b0);
    #2;
    rst_n       = 1'b0;
    bus.din_vld = 1'b0;
    bus.din_sof = 1'b0;
    #1;
    n_checks++;
    if ({bus.dout, bus.dout_valid, bus.overflow} !== {WORD_W+2{1'b0}}) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h/%b/%b expected 0/0/0", bus.dout, bus.dout_valid, bus.overflow);
    end
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    send_word(8'h96, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (bus.dout !== 8'h96 || bus.dout_valid !== 1'b1 || e_dout !== 8'h96) begin
      n_fail++;
      $display("FAIL midreset_word: got dout=%h valid=%b expected 96/1", bus.dout, bus.dout_valid);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [WORD_W-1:0] sent [4];
    logic [WORD_W-1:0] got  [$];
    for (int k = 0; k < 4; k++) sent[k] = WORD_W'($urandom);
    for (int k = 0; k < 4 * PAIRS + 2; k++) begin
      if (k < 4 * PAIRS)
        drive_cycle(1'b1, (k % PAIRS) == 0, sent[k / PAIRS][WORD_W-1-2*(k%PAIRS)],
                    sent[k / PAIRS][WORD_W-2-2*(k%PAIRS)], 1'b1, 1'b0);
      else
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (bus.dout_valid === 1'b1) got.push_back(bus.dout);
    end
    n_checks++;
    if (got.size() !== 4) begin
      n_fail++; $display("FAIL b2b_count: got %0d words expected 4", got.size());
    end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      n_checks++;
      if (got[k] !== sent[k]) begin
        n_fail++; $display("FAIL b2b_word%0d: got %h expected %h", k, got[k], sent[k]);
      end
    end
    n_checks++;
    if (bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL b2b_overflow: got %b expected 0", bus.overflow);
    end
  endtask

  task automatic test_clr_ovf();
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.overflow !== 1'b1) begin
      n_fail++; $display("FAIL clr_set: got %b expected 1", bus.overflow);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL clr_clear: got %b expected 0", bus.overflow);
    end
    send_word(8'h33, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (bus.overflow !== 1'b1) begin
      n_fail++; $display("FAIL clr_drop_wins: got %b expected 1", bus.overflow);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if ({bus.dout, bus.dout_valid, bus.overflow} !== {8'h11, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL clr_accept: got %h/%b/%b expected 11/0/0", bus.dout, bus.dout_valid, bus.overflow);
    end
  endtask

  task automatic test_random();
    logic vld;
    logic sof;
    logic rdy;
    logic clr;
    for (int i = 0; i < 400; i++) begin
      vld = ($urandom_range(99, 0) < 75);
      sof = vld && ($urandom_range(99, 0) < 10);
      rdy = ($urandom_range(99, 0) < 55);
      clr = ($urandom_range(99, 0) < 8);
      drive_cycle(vld, sof, 1'($urandom), 1'($urandom), rdy, clr);
      n_checks++;
      if ({bus.dout, bus.dout_valid, bus.overflow} !== {e_dout, e_valid, e_ovf}) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h/%b/%b expected %h/%b/%b", i,
                 bus.dout, bus.dout_valid, bus.overflow, e_dout, e_valid, e_ovf);
      end
    end
  endtask

  initial begin
    bus.din        = 1'b0;
    bus.din_vld    = 1'b0;
    bus.din_sof    = 1'b0;
    bus.dout_ready = 1'b0;
    bus.clr_ovf    = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_resync();
    test_reset_mid();
    test_back_to_back();
    test_clr_ovf();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
